// File: rtl/exp_align_seq_if.sv
// Handshake and control bundle between the exponent-align sequencer and its
// neighbours (operand buffer / exp-match stage upstream, adder tree / accumulator downstream).
interface exp_align_seq_if #(
    parameter int ACC_EXP_WIDTH = 6,
    parameter int CNT_WIDTH     = 8
);
    logic                     start;
    logic [CNT_WIDTH-1:0]     num_chunk;
    logic                     busy;
    logic                     chunk_valid;
    logic                     chunk_ready;
    logic [ACC_EXP_WIDTH-1:0] chunk_max_exp;
    logic                     acc_clear;
    logic                     acc_en;
    logic [ACC_EXP_WIDTH-1:0] acc_shift;
    logic [ACC_EXP_WIDTH-1:0] psum_shift;
    logic [ACC_EXP_WIDTH-1:0] acc_exp;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_EXP_WIDTH-1:0] res_exp;

    // The sequencer itself
    modport master (
        input  start, num_chunk, chunk_valid, chunk_max_exp, res_ready,
        output busy, chunk_ready, acc_clear, acc_en, acc_shift, psum_shift,
               acc_exp, res_valid, res_exp
    );

    // The surrounding environment that feeds chunks and consumes the result
    modport slave (
        output start, num_chunk, chunk_valid, chunk_max_exp, res_ready,
        input  busy, chunk_ready, acc_clear, acc_en, acc_shift, psum_shift,
               acc_exp, res_valid, res_exp
    );
endinterface

// File: rtl/exp_align_seq.sv
// Dot-product exponent sequencer: tracks the running accumulator exponent across
// chunks and emits per-chunk realignment shifts with accumulate strobes.
module exp_align_seq #(
    parameter int ACC_EXP_WIDTH = 6,
    parameter int CNT_WIDTH     = 8
) (
    input logic              clk,
    input logic              reset,
    exp_align_seq_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state;
    logic [CNT_WIDTH-1:0]     remaining;
    logic                     first_chunk;
    logic                     acc_clear_q;
    logic                     acc_en_q;
    logic [ACC_EXP_WIDTH-1:0] acc_shift_q;
    logic [ACC_EXP_WIDTH-1:0] psum_shift_q;
    logic [ACC_EXP_WIDTH-1:0] acc_exp_q;
    logic                     accept;

    assign accept = (state == RUN) && bus.chunk_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            first_chunk  <= 1'b0;
            acc_clear_q  <= 1'b0;
            acc_en_q     <= 1'b0;
            acc_shift_q  <= '0;
            psum_shift_q <= '0;
            acc_exp_q    <= '0;
        end else begin
            acc_clear_q <= 1'b0;
            acc_en_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.num_chunk != '0)) begin
                        remaining   <= bus.num_chunk;
                        first_chunk <= 1'b1;
                        acc_clear_q <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_en_q    <= 1'b1;
                        first_chunk <= 1'b0;
                        remaining   <= remaining - 1'b1;
                        // Whichever side has the smaller exponent is shifted down to match the larger
                        if (first_chunk) begin
                            acc_exp_q    <= bus.chunk_max_exp;
                            acc_shift_q  <= '0;
                            psum_shift_q <= '0;
                        end else if (bus.chunk_max_exp > acc_exp_q) begin
                            acc_exp_q    <= bus.chunk_max_exp;
                            acc_shift_q  <= bus.chunk_max_exp - acc_exp_q;
                            psum_shift_q <= '0;
                        end else begin
                            acc_shift_q  <= '0;
                            psum_shift_q <= acc_exp_q - bus.chunk_max_exp;
                        end
                        if (remaining == CNT_WIDTH'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.chunk_ready = (state == RUN);
    assign bus.acc_clear   = acc_clear_q;
    assign bus.acc_en      = acc_en_q;
    assign bus.acc_shift   = acc_shift_q;
    assign bus.psum_shift  = psum_shift_q;
    assign bus.acc_exp     = acc_exp_q;
    assign bus.res_valid   = (state == DONE);
    assign bus.res_exp     = (state == DONE) ? acc_exp_q : '0;
endmodule

// File: tb/tb_exp_align_seq.sv
// Self-checking bench for exp_align_seq: vector table of dot products with a
// shift scoreboard, plus hand-written reset and zero-count sequences.
module tb_exp_align_seq;
    logic clk;
    logic reset;
    int   cmp_count;
    int   err_count;

    typedef struct packed {
        logic [7:0]      num;
        logic [0:3][5:0] exps;
        logic [0:3][5:0] acc_sh;
        logic [0:3][5:0] ps_sh;
        logic [3:0]      gap;
        logic [3:0]      hold;
        logic [5:0]      res;
    } vec_t;

    vec_t        vecs [6];
    logic [11:0] sb_q [$];

    exp_align_seq_if #(.ACC_EXP_WIDTH(6), .CNT_WIDTH(8)) bus ();

    exp_align_seq #(.ACC_EXP_WIDTH(6), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        cmp_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {3'b0, bus.busy, bus.chunk_ready, bus.acc_clear, bus.acc_en,
                bus.acc_shift, bus.psum_shift, bus.acc_exp, bus.res_valid, bus.res_exp[4:0]}
               | {26'b0, bus.res_exp[5], 5'b0};
    endfunction

    // Every accumulate strobe must match the oldest pending expected shift pair
    always @(negedge clk) begin
        if (bus.acc_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected acc_en", 32'd1, 32'd0);
            end else begin
                checkOutput("acc_en shifts", {20'b0, bus.acc_shift, bus.psum_shift}, {20'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        bus.start     = 1'b1;
        bus.num_chunk = v.num;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("acc_clear after start", {29'b0, bus.acc_clear, bus.chunk_ready, bus.busy}, 32'h7);
        for (int i = 0; i < int'(v.num); i++) begin
            if (i > 0) begin
                for (int g = 0; g < int'(v.gap); g++) begin
                    bus.chunk_valid = 1'b0;
                    bus.start       = (g == 0);
                    bus.num_chunk   = 8'd5;
                    @(posedge clk);
                    @(negedge clk);
                    bus.start = 1'b0;
                    checkOutput("acc_en during gap", {31'b0, bus.acc_en}, 32'd0);
                end
            end
            bus.chunk_valid   = 1'b1;
            bus.chunk_max_exp = v.exps[i];
            checkOutput("chunk_ready", {31'b0, bus.chunk_ready}, 32'd1);
            sb_q.push_back({v.acc_sh[i], v.ps_sh[i]});
            @(posedge clk);
            @(negedge clk);
            checkOutput("acc_en after accept", {31'b0, bus.acc_en}, 32'd1);
        end
        bus.chunk_valid = 1'b0;
        checkOutput("flush cycle", {30'b0, bus.res_valid, bus.chunk_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("res_valid latency", {31'b0, bus.res_valid}, 32'd1);
        checkOutput("res_exp", {26'b0, bus.res_exp}, {26'b0, v.res});
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.start     = (h == 0);
            bus.num_chunk = 8'd2;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput("done hold", {24'b0, bus.busy, bus.res_valid, bus.res_exp}, {24'b0, 2'b11, v.res});
        end
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        bus.num_chunk = 8'd2;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        checkOutput("after res_ready", {24'b0, bus.busy, bus.res_valid, bus.acc_exp}, {24'b0, 2'b00, v.res});
        checkOutput("scoreboard drained", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmp_count         = 0;
        err_count         = 0;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.num_chunk     = '0;
        bus.chunk_valid   = 1'b0;
        bus.chunk_max_exp = '0;
        bus.res_ready     = 1'b0;

        //                num    exps               acc_sh            ps_sh             gap   hold  res
        vecs[0] = '{8'd3, {6'd5, 6'd9, 6'd7, 6'd0},  {6'd0, 6'd4, 6'd0, 6'd0},  {6'd0, 6'd0, 6'd2, 6'd0}, 4'd0, 4'd0, 6'd9};
        vecs[1] = '{8'd2, {6'd12, 6'd3, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0},  {6'd0, 6'd9, 6'd0, 6'd0}, 4'd3, 4'd5, 6'd12};
        vecs[2] = '{8'd1, {6'd63, 6'd0, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0},  {6'd0, 6'd0, 6'd0, 6'd0}, 4'd0, 4'd1, 6'd63};
        vecs[3] = '{8'd2, {6'd0, 6'd63, 6'd0, 6'd0}, {6'd0, 6'd63, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, 4'd0, 4'd0, 6'd63};
        vecs[4] = '{8'd2, {6'd63, 6'd0, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0},  {6'd0, 6'd63, 6'd0, 6'd0}, 4'd1, 4'd0, 6'd63};
        vecs[5] = '{8'd4, {6'd10, 6'd10, 6'd20, 6'd15}, {6'd0, 6'd0, 6'd10, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd5}, 4'd0, 4'd2, 6'd20};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("outputs in reset", allOutputs(), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("outputs after reset", allOutputs(), 32'd0);

        // A zero chunk count must not leave IDLE
        bus.start     = 1'b1;
        bus.num_chunk = 8'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("zero count ignored", {30'b0, bus.busy, bus.acc_clear}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
        end

        // Abort a four-chunk dot product after its first chunk
        bus.start     = 1'b1;
        bus.num_chunk = 8'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start         = 1'b0;
        bus.chunk_valid   = 1'b1;
        bus.chunk_max_exp = 6'd33;
        sb_q.push_back(12'h000);
        @(posedge clk);
        @(negedge clk);
        checkOutput("acc_en before abort", {31'b0, bus.acc_en}, 32'd1);
        bus.chunk_valid = 1'b0;
        reset           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("outputs after abort", allOutputs(), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle after abort", {30'b0, bus.busy, bus.res_valid}, 32'd0);
        end

        applyStimulus(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
